// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the 7-segment scan receiver.
//   - Active-high segment patterns (g..a) for hex digits 0..F.
//   - Bit positions of the segment field and decimal point in SEG.
//   - FSM state type used by seg_scan_decoder.
//   - is_onehot(): single-bit test used on the normalised SEL sample.
package seg_scan_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;
    localparam logic [6:0] PAT_A = 7'h77;
    localparam logic [6:0] PAT_B = 7'h7C;
    localparam logic [6:0] PAT_C = 7'h39;
    localparam logic [6:0] PAT_D = 7'h5E;
    localparam logic [6:0] PAT_E = 7'h79;
    localparam logic [6:0] PAT_F = 7'h71;

    typedef enum logic {
        WAIT_STABLE,
        CAPTURED
    } state_t;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational decode of an active-high segment
// pattern (bit0=a .. bit6=g) into a hex nibble.
// Configuration macro: SEG_DECODE_HEX_EN -- when defined, A..F patterns are
// legal (10..15); otherwise only 0..9 are legal and A..F count as illegal.
// Ports:
//   pattern  in  7  active-high segments g..a
//   legal    out 1  pattern is a recognised digit
//   blank    out 1  pattern is all segments off
//   nibble   out 4  decoded value (0 when not legal)
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        legal  = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (pattern)
            PAT_0: nibble = 4'h0;
            PAT_1: nibble = 4'h1;
            PAT_2: nibble = 4'h2;
            PAT_3: nibble = 4'h3;
            PAT_4: nibble = 4'h4;
            PAT_5: nibble = 4'h5;
            PAT_6: nibble = 4'h6;
            PAT_7: nibble = 4'h7;
            PAT_8: nibble = 4'h8;
            PAT_9: nibble = 4'h9;
`ifdef SEG_DECODE_HEX_EN
            PAT_A: nibble = 4'hA;
            PAT_B: nibble = 4'hB;
            PAT_C: nibble = 4'hC;
            PAT_D: nibble = 4'hD;
            PAT_E: nibble = 4'hE;
            PAT_F: nibble = 4'hF;
`endif
            7'h00: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receives a multiplexed 8-digit 7-segment scan (SEL/SEG),
// waits for each digit slot to be stable for SETTLE_CNT sampled cycles,
// captures it once per dwell and decodes it to a hex nibble per digit.
// Configuration macro: SEG_DECODE_HEX_EN (see seg7_pattern_decode).
// Ports:
//   Clk         in   1  system clock
//   Reset       in   1  synchronous, active-high reset
//   SEL         in   8  digit select, bit i = digit i
//   SEG         in   8  segments, bit0=a .. bit6=g, bit7=dp
//   Digits      out 32  Digits[4i+3:4i] = decoded digit i
//   Dp          out  8  decimal point per digit
//   Valid       out  8  digit i holds a legally decoded value
//   Blank       out  8  digit i last seen with all segments off
//   Frame_done  out  1  pulse: all 8 slots captured since last pulse
//   Err         out  1  pulse: illegal SEL or SEG pattern captured
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CNT     = 50,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  SEL,
    input  logic [7:0]  SEG,
    output logic [31:0] Digits,
    output logic [7:0]  Dp,
    output logic [7:0]  Valid,
    output logic [7:0]  Blank,
    output logic        Frame_done,
    output logic        Err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CNT - 1);
    // Capture fires on the edge where the counter steps onto CNT_MAX, which
    // puts the outputs SETTLE_CNT+1 clocks after the last input change.
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(SETTLE_CNT - 2);

    logic [7:0]       sel_norm, seg_norm;
    logic [7:0]       sel_q, seg_q, sel_prev, seg_prev;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       seen;
    state_t           state;

    logic             sample_same;
    logic             capture;
    logic [2:0]       slot;
    logic             pat_legal, pat_blank;
    logic [3:0]       pat_nibble;

    // Everything downstream of this point works in active-high terms.
    assign sel_norm = SEL_ACTIVE_LOW ? ~SEL : SEL;
    assign seg_norm = SEG_ACTIVE_LOW ? ~SEG : SEG;

    assign sample_same = (sel_q == sel_prev) && (seg_q == seg_prev);
    assign capture     = sample_same && (state == WAIT_STABLE) && (cnt_q == CNT_ARM);

    always_comb begin
        slot = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel_q[i]) slot = 3'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_q[SEG_G:SEG_A]),
        .legal   (pat_legal),
        .blank   (pat_blank),
        .nibble  (pat_nibble)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q      <= 8'd0;
            seg_q      <= 8'd0;
            sel_prev   <= 8'd0;
            seg_prev   <= 8'd0;
            cnt_q      <= '0;
            seen       <= 8'd0;
            state      <= WAIT_STABLE;
            Digits     <= 32'd0;
            Dp         <= 8'd0;
            Valid      <= 8'd0;
            Blank      <= 8'd0;
            Frame_done <= 1'b0;
            Err        <= 1'b0;
        end else begin
            sel_q      <= sel_norm;
            seg_q      <= seg_norm;
            sel_prev   <= sel_q;
            seg_prev   <= seg_q;
            Frame_done <= 1'b0;
            Err        <= 1'b0;

            if (!sample_same)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);

            case (state)
                WAIT_STABLE: begin
                    // All-zero SEL is inter-digit blanking: keep waiting.
                    if (capture && (sel_q != 8'd0)) begin
                        state <= CAPTURED;
                        if (is_onehot(sel_q)) begin
                            Dp[slot] <= seg_q[SEG_DP];
                            if (pat_legal) begin
                                Digits[{slot, 2'b00} +: 4] <= pat_nibble;
                                Valid[slot] <= 1'b1;
                                Blank[slot] <= 1'b0;
                            end else if (pat_blank) begin
                                Valid[slot] <= 1'b0;
                                Blank[slot] <= 1'b1;
                            end else begin
                                // Lit but unrecognised: not blank either.
                                Valid[slot] <= 1'b0;
                                Blank[slot] <= 1'b0;
                                Err         <= 1'b1;
                            end
                            // Erroneous slots still count towards the frame.
                            if ((seen | sel_q) == 8'hFF) begin
                                seen       <= 8'd0;
                                Frame_done <= 1'b1;
                            end else begin
                                seen <= seen | sel_q;
                            end
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                CAPTURED: begin
                    if (!sample_same) state <= WAIT_STABLE;
                end
                default: state <= WAIT_STABLE;
            endcase
        end
    end

endmodule
